// File: rtl/slow_arith_pkg.sv
// slow_arith_pkg: shared state encoding and default widths for the slow multiplier and divider.
package slow_arith_pkg;
  localparam int A_W = 8;
  localparam int B_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/slow_mul_datapath.sv
// slow_mul_datapath: accumulator, shifting multiplicand and multiplier registers for one add-shift step per enable.
module slow_mul_datapath #(
  parameter int A_W = 8,
  parameter int B_W = 4,
  parameter int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  input  logic [B_W-1:0] i_c,
  output logic [P_W-1:0] o_acc
);
  logic [P_W-1:0] r_acc;
  logic [P_W-1:0] r_mreg;
  logic [B_W-1:0] r_breg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_mreg <= '0;
      r_breg <= '0;
    end else if (i_load) begin
      r_acc  <= P_W'(i_c);
      r_mreg <= P_W'(i_a);
      r_breg <= i_b;
    end else if (i_step) begin
      r_acc  <= r_breg[0] ? r_acc + r_mreg : r_acc;
      r_mreg <= r_mreg << 1;
      r_breg <= r_breg >> 1;
    end
  end
  assign o_acc = r_acc;
endmodule

// File: rtl/slow_multiplier.sv
// slow_multiplier: shift-and-add multiplier, one multiplier bit per clock, start/busy/done handshake.
// Define SLOW_MUL_ADDEND_EN to add the addend port (product = multiplicand*multiplier + addend).
module slow_multiplier
  import slow_arith_pkg::*;
#(
  parameter int A_W = slow_arith_pkg::A_W,
  parameter int B_W = slow_arith_pkg::B_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [A_W-1:0]       multiplicand,
  input  logic [B_W-1:0]       multiplier,
`ifdef SLOW_MUL_ADDEND_EN
  input  logic [B_W-1:0]       addend,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [A_W+B_W-1:0]   product
);
  localparam int P_W = A_W + B_W;
  localparam int C_W = $clog2(B_W + 1);
  localparam logic [C_W-1:0] LAST = C_W'(B_W - 1);
  state_t         r_state;
  logic [C_W-1:0] r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [P_W-1:0] r_product;
  logic [P_W-1:0] w_acc;
  logic [B_W-1:0] w_addend;
  logic           w_load;
  logic           w_step;
`ifdef SLOW_MUL_ADDEND_EN
  assign w_addend = addend;
`else
  assign w_addend = '0;
`endif
  assign w_load = start && (r_state == IDLE || r_state == DONE);
  assign w_step = r_state == RUN;
  slow_mul_datapath #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_dp (
    .clk    (clk),
    .reset_n(reset_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_a    (multiplicand),
    .i_b    (multiplier),
    .i_c    (w_addend),
    .o_acc  (w_acc)
  );
  // Outputs lag the state by one cycle, so DONE's final acc lands with the done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_busy    <= r_state == RUN;
      r_done    <= r_state == DONE;
      r_product <= r_state == DONE ? w_acc : r_product;
      r_cnt     <= w_load ? '0 : w_step ? r_cnt + 1'b1 : r_cnt;
      r_state   <= w_load                      ? RUN  :
                   (w_step && r_cnt == LAST)   ? DONE :
                   (r_state == RUN)            ? RUN  : IDLE;
    end
  end
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
endmodule

// File: tb/tb_slow_multiplier.sv
// tb_slow_multiplier: directed vector table plus handshake, back-to-back and reset-abort sequences.
module tb_slow_multiplier;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [3:0]  multiplier = '0;
  logic [3:0]  addend = '0;
  logic        busy;
  logic        done;
  logic [11:0] product;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slow_multiplier dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
`ifdef SLOW_MUL_ADDEND_EN
    .addend      (addend),
`endif
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  typedef struct {
    logic [7:0]  a;
    logic [3:0]  b;
    logic [3:0]  c;
    logic [11:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start one operation from IDLE and wait (bounded) for done; reports product, latency, busy cycles, overlap.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input logic [3:0] c,
                       output logic [11:0] p, output int lat, output int bc, output int ov);
    @(negedge clk);
    multiplicand = a; multiplier = b; addend = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0; bc = 0; ov = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
      if (busy && done) ov++;
    end
    p = product;
  endtask

  initial begin
    vec_t vecs[$];
    logic [11:0] p;
    int lat, bc, ov, nd;
    int dt[$];
    logic [11:0] dp[$];
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [11:0] p;
    int lat, bc, ov, nd;
    int dt[$];
    logic [11:0] dp[$];
    vecs.push_back('{8'd13,  4'd9,  4'd0, 12'd117});
    vecs.push_back('{8'd255, 4'd15, 4'd0, 12'd3825});
    vecs.push_back('{8'd0,   4'd15, 4'd0, 12'd0});
    vecs.push_back('{8'd255, 4'd0,  4'd0, 12'd0});
    vecs.push_back('{8'd1,   4'd1,  4'd0, 12'd1});
    vecs.push_back('{8'd128, 4'd8,  4'd0, 12'd1024});
    vecs.push_back('{8'd170, 4'd5,  4'd0, 12'd850});
    vecs.push_back('{8'd85,  4'd10, 4'd0, 12'd850});
    vecs.push_back('{8'd200, 4'd13, 4'd0, 12'd2600});
`ifdef SLOW_MUL_ADDEND_EN
    vecs.push_back('{8'd25,  4'd6,  4'd3, 12'd153});
    vecs.push_back('{8'd255, 4'd15, 4'd15, 12'd3840});
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_product", {20'd0, product}, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_done", {31'd0, done}, 0);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].c, p, lat, bc, ov);
      check($sformatf("vec%0d_product", i), {20'd0, p}, {20'd0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_busy_cycles", i), bc, 4);
      check($sformatf("vec%0d_overlap", i), ov, 0);
    end

    // start held high: second operands captured in DONE, results 5 cycles apart
    @(negedge clk);
    multiplicand = 8'd13; multiplier = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    multiplicand = 8'd255; multiplier = 4'd15;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c == 6) start = 1'b0;
      if (done) begin dt.push_back(c); dp.push_back(product); end
    end
    check("b2b_count", dt.size(), 2);
    if (dt.size() == 2) begin
      check("b2b_t0", dt[0], 5);
      check("b2b_t1", dt[1], 10);
      check("b2b_p0", {20'd0, dp[0]}, 117);
      check("b2b_p1", {20'd0, dp[1]}, 3825);
    end

    // start pulsed during RUN with new operands must be ignored
    @(negedge clk);
    multiplicand = 8'd25; multiplier = 4'd6; addend = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; lat = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 2) begin multiplicand = 8'd255; multiplier = 4'd15; start = 1'b1; end
      if (c == 3) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin nd++; lat = c; p = product; end
    end
    check("run_start_done_count", nd, 1);
    check("run_start_latency", lat, 5);
    check("run_start_product", {20'd0, p}, 150);

    // asynchronous reset during the second RUN cycle
    @(negedge clk);
    multiplicand = 8'd13; multiplier = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_abort_busy", {31'd0, busy}, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_product", {20'd0, product}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    check("post_abort_quiet", nd, 0);
    do_op(8'd7, 4'd3, 4'd0, p, lat, bc, ov);
    check("post_abort_product", {20'd0, p}, 21);
    check("post_abort_latency", lat, 5);

`ifdef SLOW_MUL_ADDEND_EN
    for (int d = 0; d < 256; d++)
      for (int v = 1; v < 16; v++) begin
        do_op(8'(d / v), 4'(v), 4'(d % v), p, lat, bc, ov);
        check($sformatf("rebuild_%0d_%0d", d, v), {20'd0, p}, d);
      end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/slow_multiplier.md
# slow_multiplier

Sequential shift-and-add multiplier: the inverse datapath of the team's bit-serial restoring divider. Given a quotient-width multiplicand and a divisor-width multiplier, it produces the full-width product one multiplier bit per clock. It is used to reconstruct and check dividends (quotient × divisor + remainder) in division self-test, and as a standalone low-area multiplier. A start/busy/done handshake gives it a fixed, deterministic latency.

## Interface
- A_W, default 8: multiplicand width (matches divider quotient/dividend width)
- B_W, default 4: multiplier width (matches divider divisor/remainder width)
- P_W, default A_W+B_W: product width (derived, not overridden)
- clk  input  1  rising-edge clock; single clock domain
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- multiplicand  input  A_W  operand A, captured on accepted start
- multiplier  input  B_W  operand B, captured on accepted start
- addend  input  B_W  operand C, captured on accepted start (present only with SLOW_MUL_ADDEND_EN)
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle pulse: product valid
- product  output  P_W  result; held stable from done until the next done

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → capture operands, go to RUN; otherwise stay.
- On capture: acc ← addend zero-extended to P_W (0 without the macro); mreg ← multiplicand zero-extended to P_W; breg ← multiplier; cnt ← 0.
- RUN, each cycle: if breg[0], acc ← acc + mreg (P_W-bit, no overflow possible); mreg ← mreg << 1; breg ← breg >> 1; cnt ← cnt + 1. After cycle with cnt = B_W−1 → DONE.
- DONE: product ← acc is registered on entry; done=1 for exactly this cycle. start=1 → capture new operands, go to RUN (back-to-back); else → IDLE.
- start during RUN is ignored; operands are not re-sampled.
- Width rule: (2^A_W−1)(2^B_W−1)+(2^B_W−1) < 2^P_W, so no overflow flag is needed.
- No early termination: RUN always lasts exactly B_W cycles, including for zero operands.

## Timing
- Reset values: busy=0, done=0, product=0; state IDLE; acc, mreg, breg, cnt = 0.
- Reset assertion mid-operation aborts immediately and asynchronously; the partial result is discarded, and no done is produced after release.
- start sampled at edge k (IDLE) → busy high edges k+1..k+B_W → done high for the cycle after edge k+B_W+1, with product valid in that same cycle. Latency from start edge to done: B_W+1 cycles.
- Back-to-back throughput: one result per B_W+1 cycles.
- busy and done are never high simultaneously.

## Configuration
- SLOW_MUL_ADDEND_EN defined: addend port exists; acc initialises to addend, and product = multiplicand×multiplier + addend. Used to rebuild dividend = quotient×divisor + remainder.
- Not defined: no addend port; acc initialises to 0, and product = multiplicand×multiplier. Timing is identical in both builds.

## Structure
- Shared package slow_arith_pkg: the state enum (IDLE/RUN/DONE) and the default width constants A_W=8, B_W=4. The divider uses the same constants.
- One sub-module, slow_mul_datapath, holds acc/mreg/breg and the add-shift step, with load and step enables. The FSM, cnt and handshake stay in the top level.

## Test plan
- 13×9 → done 5 cycles after start, product=117 (0x075), busy high for exactly 4 cycles.
- 255×15 → product=3825 (0xEF1); 0×15 and 255×0 → product=0, same 5-cycle latency.
- With SLOW_MUL_ADDEND_EN: 25×6+3 → 153. Sweep all dividends 0..255 with divisors 1..15 and check quotient×divisor+remainder = dividend.
- start held high: results at 5-cycle spacing (back-to-back accepted in DONE). start pulsed during RUN is ignored; the original operands' product is reported.
- reset_n low at the 2nd RUN cycle → busy, done and product go to 0 immediately. After release: IDLE, no spurious done; next start (7×3) → 21.
